pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Instruction-field pipeline and hazard unit. Sits upstream of the stage decoder.
//  Carries opcode/funct/register fields through FD->DX->XM->MW, so the decoder sees per-stage opcode/funct.
//  Detects load-use and branch-operand hazards, stalls PC/FD, injects bubbles, squashes FD on redirect.
//  Generates ALU operand forwarding selects.
// PARAMETERS
//  INSTR_W   32      instruction width
//  RA_W      5       register address width
//  NOP_INSTR 32'h0   bubble/reset instruction (opcode 0, funct 0, all regs 0)
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  reset       in   1   asynchronous, active-high; clears all stage registers to NOP_INSTR fields
//  if_instr    in   32  instruction fetched this cycle
//  d_redirect  in   1   OR of decoder PC-source outputs (jump/taken branch/JR); squash the IF instruction
//  ext_stall   in   1   memory not ready; freeze every stage register
//  pc_stall    out  1   hold PC (load-use/branch hazard OR ext_stall)
//  fd_opcode   out  6   FD opcode        | fd_funct  out 6 | fd_rs, fd_rt out RA_W
//  dx_opcode   out  6   DX opcode        | dx_funct  out 6 | dx_rs, dx_rt out RA_W
//  xm_opcode   out  6   XM opcode        | xm_dest   out RA_W
//  mw_opcode   out  6   MW opcode        | mw_funct  out 6 | mw_dest out RA_W
//  fwd_a       out  2   ALU src A select: 0 regfile, 1 XM result, 2 MW result
//  fwd_b       out  2   ALU src B select, same encoding
// BEHAVIOUR
//  - Reset: all stage fields 0 (opcode 0, funct 0, dests 0); pc_stall=0; fwd_a=fwd_b=0.
//  - dest(stage): R-type (op 0, funct != JR) -> rd; JAL -> 31; ADDI/ANDI/ORI/XORI/SLTI/LW/LB -> rt;
//    SW, SB, BEQ, BNE, J, JR -> 0. Dest 0 never creates a hazard or forward.
//  - Hazard h (combinational):
//    load-use: dx_op in {LW,LB} and dx_dest!=0 and dx_dest in {fd_rs, fd_rt used by fd instr};
//    branch: fd_op in {BEQ,BNE} or fd is JR, and (dx_dest or load-in-XM xm_dest) matches a used rs/rt.
//    "Used": rt counts only for R-type, BEQ/BNE, SW/SB.
//  - Each edge, in priority order:
//    ext_stall=1: all stage registers hold.
//    h=1: PC and FD hold; DX <= NOP; XM<=DX; MW<=XM.
//    d_redirect=1 (and h=0): FD <= NOP (if_instr discarded); others advance.
//    otherwise: all stages advance; FD <= if_instr.
//  - d_redirect while h=1 is ignored (decoder redirect is invalid under stall).
//  - pc_stall = h | ext_stall, combinational, same cycle.
//  - Forwarding (combinational, on DX): fwd_a=1 if xm_dest!=0 & xm_dest==dx_rs & XM not a load;
//    else 2 if mw_dest!=0 & mw_dest==dx_rs; else 0. fwd_b likewise on dx_rt. XM wins over MW.
//  - Regfile writes in first half cycle and reads in second; MW->FD needs no stall.
//  - Reset mid-stall: all stages to NOP; pc_stall drops asynchronously with reset.
// CONFIGURATION
//  PIPE_FORWARD_EN defined: forwarding as above; hazard h covers only load-use and branch cases.
//  Undefined: fwd_a=fwd_b=0 constant. h also asserts on any DX or XM dest matching a used FD source
//    (full RAW interlock).
// STRUCTURE
//  mips_pkg: opcode/funct constants (ADD..XOR, ADDI..XORI, LW/LB/SW/SB, BEQ/BNE, J/JAL/JR)
//    and NOP_INSTR; shared with the stage decoder.
//  Sub-module hazard_detect: combinational dest decode, uses-rs/rt, h, and fwd_a/fwd_b.
//  Top-level holds the four stage registers and stall/flush muxing.
// TESTING
//  1. LW $2,0($1) then ADD $3,$2,$4 -> pc_stall=1 one cycle; DX bubble (op 0); ADD reaches DX next with fwd_a=2.
//  2. ADD $5,$1,$1; SUB $6,$5,$5 (FORWARD_EN) -> no stall; SUB in DX: fwd_a=1, fwd_b=1.
//  3. BEQ in FD with d_redirect=1 -> next FD = opcode 0/funct 0; fetched instruction never reaches DX.
//  4. ADDI $7,$0,1 then BEQ $7,$0 -> 1 stall cycle (dx_dest=7). LW $7 then BEQ $7 -> 2 stall cycles.
//  5. ext_stall=1 for 3 cycles mid-stream -> all stage outputs constant; stream resumes unchanged.
//  6. reset pulse during load-use stall -> all outputs 0 immediately; clean restart from if_instr.

Source files
------------

// File: rtl/mips_pkg.sv
// MIPS instruction-field constants and field/decode helpers, shared with the stage decoder.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
//
// Contents: opcode/funct encodings, NOP_INSTR, forwarding-select encoding,
// and helpers for field extraction, destination decode and source-use decode.
package mips_pkg;

   localparam int MIPS_INSTR_W = 32;
   localparam int MIPS_RA_W    = 5;
   localparam logic [MIPS_INSTR_W-1:0] MIPS_NOP_INSTR = 32'h0000_0000;

   typedef logic [MIPS_INSTR_W-1:0] instr_t;
   typedef logic [MIPS_RA_W-1:0]    reg_t;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam reg_t REG_RA = 5'd31;

   // ALU operand source select
   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_XM = 2'd1,
      FWD_MW = 2'd2
   } fwd_sel_t;

   function automatic logic [5:0] op_of(input instr_t i);
      return i[31:26];
   endfunction

   function automatic logic [5:0] fn_of(input instr_t i);
      return i[5:0];
   endfunction

   function automatic reg_t rs_of(input instr_t i);
      return i[25:21];
   endfunction

   function automatic reg_t rt_of(input instr_t i);
      return i[20:16];
   endfunction

   function automatic reg_t rd_of(input instr_t i);
      return i[15:11];
   endfunction

   function automatic logic is_jr(input instr_t i);
      return (op_of(i) == OP_RTYPE) && (fn_of(i) == FN_JR);
   endfunction

   // JR shares the R-type opcode but neither writes rd nor reads rt
   function automatic logic is_rtype(input instr_t i);
      return (op_of(i) == OP_RTYPE) && (fn_of(i) != FN_JR);
   endfunction

   function automatic logic is_load(input instr_t i);
      return (op_of(i) == OP_LW) || (op_of(i) == OP_LB);
   endfunction

   function automatic logic is_branch(input instr_t i);
      return (op_of(i) == OP_BEQ) || (op_of(i) == OP_BNE);
   endfunction

   function automatic logic is_store(input instr_t i);
      return (op_of(i) == OP_SW) || (op_of(i) == OP_SB);
   endfunction

   // Register written by the instruction; 0 means "writes nothing"
   function automatic reg_t dest_of(input instr_t i);
      reg_t d;
      d = '0;
      case (op_of(i))
         OP_RTYPE: d = (fn_of(i) == FN_JR) ? '0 : rd_of(i);
         OP_JAL:   d = REG_RA;
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LW, OP_LB: d = rt_of(i);
         default:  d = '0;
      endcase
      return d;
   endfunction

   // Jumps carry a target in the rs/rt bit positions, so they read no register
   function automatic logic uses_rs(input instr_t i);
      return (op_of(i) != OP_J) && (op_of(i) != OP_JAL);
   endfunction

   // In I-type ALU ops and loads rt is the destination, not a source
   function automatic logic uses_rt(input instr_t i);
      return is_rtype(i) || is_branch(i) || is_store(i);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard detection and ALU forwarding-select generation.
// Latency: purely combinational, same cycle.
// Backpressure: produces the stall request (o_hazard); holds no state itself.
//
// Ports: i_fd/i_dx/i_xm/i_mw stage instruction words; o_hazard stall request;
//        o_fwd_a/o_fwd_b ALU source selects; o_xm_dest/o_mw_dest decoded destinations.
// Build option PIPE_FORWARD_EN: defined -> bypass network in use, only load-use and
// branch-operand hazards stall; undefined -> full RAW interlock, selects tied to regfile.
module hazard_detect
   import mips_pkg::*;
(
   input  instr_t     i_fd,
   input  instr_t     i_dx,
   input  instr_t     i_xm,
   input  instr_t     i_mw,
   output logic       o_hazard,
   output logic [1:0] o_fwd_a,
   output logic [1:0] o_fwd_b,
   output reg_t       o_xm_dest,
   output reg_t       o_mw_dest
);

   reg_t w_fd_rs;
   reg_t w_fd_rt;
   reg_t w_dx_dest;
   reg_t w_xm_dest;
   reg_t w_mw_dest;
   logic w_use_rs;
   logic w_use_rt;
   logic w_dx_hit;
   logic w_xm_hit;
   logic w_load_use;
   logic w_branch_haz;

   assign w_fd_rs   = rs_of(i_fd);
   assign w_fd_rt   = rt_of(i_fd);
   assign w_use_rs  = uses_rs(i_fd);
   assign w_use_rt  = uses_rt(i_fd);
   assign w_dx_dest = dest_of(i_dx);
   assign w_xm_dest = dest_of(i_xm);
   assign w_mw_dest = dest_of(i_mw);

   // A stage "hits" when it will write a real register that FD actually reads
   assign w_dx_hit = (w_dx_dest != '0) &&
                     ((w_use_rs && (w_dx_dest == w_fd_rs)) ||
                      (w_use_rt && (w_dx_dest == w_fd_rt)));
   assign w_xm_hit = (w_xm_dest != '0) &&
                     ((w_use_rs && (w_xm_dest == w_fd_rs)) ||
                      (w_use_rt && (w_xm_dest == w_fd_rt)));

   assign w_load_use = is_load(i_dx) && w_dx_hit;

   // Branches/JR resolve in decode, so their operands cannot use the ALU bypass:
   // any DX producer stalls, and a load still in XM has no data yet either.
   assign w_branch_haz = (is_branch(i_fd) || is_jr(i_fd)) &&
                         (w_dx_hit || (is_load(i_xm) && w_xm_hit));

`ifdef PIPE_FORWARD_EN
   reg_t     w_dx_rs;
   reg_t     w_dx_rt;
   fwd_sel_t w_fwd_a;
   fwd_sel_t w_fwd_b;

   assign w_dx_rs  = rs_of(i_dx);
   assign w_dx_rt  = rt_of(i_dx);
   assign o_hazard = w_load_use | w_branch_haz;

   // XM result is younger than MW, so it wins; a load in XM has no result yet
   always_comb begin
      w_fwd_a = FWD_RF;
      w_fwd_b = FWD_RF;
      if ((w_xm_dest != '0) && (w_xm_dest == w_dx_rs) && !is_load(i_xm)) begin
         w_fwd_a = FWD_XM;
      end else if ((w_mw_dest != '0) && (w_mw_dest == w_dx_rs)) begin
         w_fwd_a = FWD_MW;
      end
      if ((w_xm_dest != '0) && (w_xm_dest == w_dx_rt) && !is_load(i_xm)) begin
         w_fwd_b = FWD_XM;
      end else if ((w_mw_dest != '0) && (w_mw_dest == w_dx_rt)) begin
         w_fwd_b = FWD_MW;
      end
   end

   assign o_fwd_a = w_fwd_a;
   assign o_fwd_b = w_fwd_b;
`else
   // No bypass: any in-flight producer ahead of MW must drain before FD proceeds.
   // MW needs no stall since the regfile writes before it is read.
   assign o_hazard = w_load_use | w_branch_haz | w_dx_hit | w_xm_hit;
   assign o_fwd_a  = FWD_RF;
   assign o_fwd_b  = FWD_RF;
`endif

   assign o_xm_dest = w_xm_dest;
   assign o_mw_dest = w_mw_dest;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Instruction-field pipeline FD->DX->XM->MW with load-use/branch stall, bubble and redirect squash.
// Latency: one stage per clock; stall/forward outputs are combinational in the same cycle.
// Backpressure: ext_stall freezes every stage; hazards hold PC/FD and inject a DX bubble.
//
// Ports: clk, reset (async, active-high); if_instr fetched word; d_redirect squashes FD;
//        ext_stall freezes all; pc_stall holds PC; per-stage opcode/funct/reg fields; fwd_a/fwd_b.
// Build option PIPE_FORWARD_EN: enables ALU forwarding (see hazard_detect); default is full interlock.
module pipe_hazard_ctrl
   import mips_pkg::*;
#(
   parameter int                 INSTR_W   = MIPS_INSTR_W,
   parameter int                 RA_W      = MIPS_RA_W,
   parameter logic [INSTR_W-1:0] NOP_INSTR = MIPS_NOP_INSTR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] if_instr,
   input  logic               d_redirect,
   input  logic               ext_stall,
   output logic               pc_stall,
   output logic [5:0]         fd_opcode,
   output logic [5:0]         fd_funct,
   output logic [RA_W-1:0]    fd_rs,
   output logic [RA_W-1:0]    fd_rt,
   output logic [5:0]         dx_opcode,
   output logic [5:0]         dx_funct,
   output logic [RA_W-1:0]    dx_rs,
   output logic [RA_W-1:0]    dx_rt,
   output logic [5:0]         xm_opcode,
   output logic [RA_W-1:0]    xm_dest,
   output logic [5:0]         mw_opcode,
   output logic [5:0]         mw_funct,
   output logic [RA_W-1:0]    mw_dest,
   output logic [1:0]         fwd_a,
   output logic [1:0]         fwd_b
);

   logic [INSTR_W-1:0] r_fd;
   logic [INSTR_W-1:0] r_dx;
   logic [INSTR_W-1:0] r_xm;
   logic [INSTR_W-1:0] r_mw;
   logic               w_hazard;
   reg_t               w_xm_dest;
   reg_t               w_mw_dest;

   hazard_detect u_hazard_detect (
      .i_fd      (r_fd),
      .i_dx      (r_dx),
      .i_xm      (r_xm),
      .i_mw      (r_mw),
      .o_hazard  (w_hazard),
      .o_fwd_a   (fwd_a),
      .o_fwd_b   (fwd_b),
      .o_xm_dest (w_xm_dest),
      .o_mw_dest (w_mw_dest)
   );

   // Priority: ext_stall freezes all > hazard (hold FD, bubble DX) > redirect squash > advance.
   // A redirect raised while stalled is ignored: the decoder's view of FD is not final yet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fd <= NOP_INSTR;
         r_dx <= NOP_INSTR;
         r_xm <= NOP_INSTR;
         r_mw <= NOP_INSTR;
      end else if (!ext_stall) begin
         r_mw <= r_xm;
         r_xm <= r_dx;
         if (w_hazard) begin
            r_dx <= NOP_INSTR;
         end else begin
            r_dx <= r_fd;
            r_fd <= d_redirect ? NOP_INSTR : if_instr;
         end
      end
   end

   // Gated by reset so the stall drops immediately when reset asserts mid-stall
   assign pc_stall = !reset && (w_hazard || ext_stall);

   assign fd_opcode = op_of(r_fd);
   assign fd_funct  = fn_of(r_fd);
   assign fd_rs     = rs_of(r_fd);
   assign fd_rt     = rt_of(r_fd);
   assign dx_opcode = op_of(r_dx);
   assign dx_funct  = fn_of(r_dx);
   assign dx_rs     = rs_of(r_dx);
   assign dx_rt     = rt_of(r_dx);
   assign xm_opcode = op_of(r_xm);
   assign xm_dest   = w_xm_dest;
   assign mw_opcode = op_of(r_mw);
   assign mw_funct  = fn_of(r_mw);
   assign mw_dest   = w_mw_dest;

endmodule
